// File: rtl/bootram_loader.sv
// Boot RAM loader: receives a framed image over a byte stream and writes it
// into four byte-lane boot RAMs. Holds the CPU in reset until a good image
// has been loaded, or until the boot window expires without any sync byte.
// Frame layout: SYNC, LEN_L, LEN_H, LEN data bytes, CSUM.
// An image is good when the data bytes plus CSUM sum to zero modulo 256.
module bootram_loader #(
  parameter int          ADDR_W    = 13,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [23:0] BOOT_WAIT = 24'd5000000,
  parameter logic [23:0] TIMEOUT   = 24'd500000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_ce,
  output logic [3:0]        ram_wre,
  output logic [ADDR_W-3:0] ram_ad,
  output logic [7:0]        ram_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // Count must be able to hold a full image length of 2**ADDR_W bytes.
  localparam int          CNT_W   = ADDR_W + 1;
  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_RUN  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         sum_q, sum_d;
  logic [23:0]        boot_q, boot_d;
  logic               seen_q, seen_d;
  logic [23:0]        ibt_q, ibt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               hold_q, hold_d;
  logic               ce_q, ce_d;
  logic [3:0]         wre_q, wre_d;
  logic [ADDR_W-3:0]  ad_q, ad_d;
  logic [7:0]         din_q, din_d;

  logic               accept;
  logic               in_frame;
  logic [15:0]        len_w;
  logic [CNT_W-1:0]   cnt_inc;
  logic [7:0]         sum_inc;

  // Ready in every loading state; never while reset is asserted or once running.
  assign rx_ready = resetn && (state_q != S_RUN);
  assign accept   = rx_valid && rx_ready;
  assign in_frame = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                    (state_q == S_DATA) || (state_q == S_CSUM);
  assign len_w    = {rx_data, len_q[7:0]};
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign sum_inc  = sum_q + rx_data;

  // Next-state logic: frame parser, timers and the one-cycle RAM write strobe.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    boot_d  = boot_q;
    seen_d  = seen_q;
    ibt_d   = ibt_q;
    done_d  = done_q;
    err_d   = err_q;
    ce_d    = 1'b0;
    wre_d   = 4'b0000;
    ad_d    = ad_q;
    din_d   = din_q;

    // Inter-byte timer only matters inside a frame; any accepted byte clears it.
    if (accept)        ibt_d = '0;
    else if (in_frame) ibt_d = ibt_q + 24'd1;
    else               ibt_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_d = S_LEN0;
          err_d   = 1'b0;
          cnt_d   = '0;
          sum_d   = '0;
          seen_d  = 1'b1;
        end else if (!seen_q) begin
          // Boot window closes for good once any sync byte has been seen.
          boot_d = boot_q + 24'd1;
          if (boot_d == BOOT_WAIT) state_d = S_RUN;
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = len_w;
          if (32'(len_w) > MAX_LEN) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else if (len_w == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          ce_d  = 1'b1;
          wre_d = 4'b0001 << cnt_q[1:0];
          ad_d  = cnt_q[ADDR_W-1:2];
          din_d = rx_data;
          sum_d = sum_inc;
          cnt_d = cnt_inc;
          if (32'(cnt_inc) == 32'(len_q)) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (sum_inc == 8'd0) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A stalled frame is abandoned; accepts never coincide with this path.
    if (!accept && in_frame && ((ibt_q + 24'd1) == TIMEOUT)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      ibt_d   = '0;
    end

    // Registered so the CPU is released in the same cycle RUN is entered.
    hold_d = (state_d != S_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      boot_q  <= '0;
      seen_q  <= 1'b0;
      ibt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
      ce_q    <= 1'b0;
      wre_q   <= '0;
      ad_q    <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      boot_q  <= boot_d;
      seen_q  <= seen_d;
      ibt_q   <= ibt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      ce_q    <= ce_d;
      wre_q   <= wre_d;
      ad_q    <= ad_d;
      din_q   <= din_d;
    end
  end

  assign ram_ce   = ce_q;
  assign ram_wre  = wre_q;
  assign ram_ad   = ad_q;
  assign ram_din  = din_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bootram_loader.sv
// Scoreboard bench for bootram_loader: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares each write the DUT presents.
module tb_bootram_loader;

  localparam int BW = 300;
  localparam int TO = 40;

  typedef struct {
    logic [3:0]  wre;
    logic [10:0] ad;
    logic [7:0]  din;
  } wr_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        ram_ce;
  logic [3:0]  ram_wre;
  logic [10:0] ram_ad;
  logic [7:0]  ram_din;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  wr_t exp_q[$];
  logic [7:0] frm[$];

  bootram_loader #(
    .ADDR_W(13), .SYNC_BYTE(8'hA5), .BOOT_WAIT(24'(BW)), .TIMEOUT(24'(TO))
  ) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_ce) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: wre=%b ad=%0h din=%0h expected none", ram_wre, ram_ad, ram_din);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_wre", 32'(ram_wre), 32'(e.wre));
          chk("wr_ad",  32'(ram_ad),  32'(e.ad));
          chk("wr_din", 32'(ram_din), 32'(e.din));
        end
      end else begin
        chk("idle_wre", 32'(ram_wre), 32'd0);
      end
    end
  end

  task automatic do_reset();
    resetn   = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Sends frm back to back; data byte i is expected at lane i%4, word i/4.
  task automatic send_frame();
    int len;
    wr_t w;
    len = (frm.size() >= 3) ? int'({frm[2], frm[1]}) : 0;
    for (int k = 0; k < frm.size(); k++) begin
      if (k >= 3 && (k - 3) < len && len <= 8192) begin
        w.wre = 4'b0001 << ((k - 3) % 4);
        w.ad  = 11'((k - 3) / 4);
        w.din = frm[k];
        exp_q.push_back(w);
      end
      send_byte(frm[k]);
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1 chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset values while resetn is held low
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ce", 32'(ram_ce), 32'd0);
    resetn = 1'b1;

    // 1: boot window expires with no traffic
    do_reset();
    repeat (BW - 1) @(posedge clk);
    #1 chk("t1_hold_before", 32'(cpu_hold), 32'd1);
    chk("t1_ready_before", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1 chk("t1_hold_at", 32'(cpu_hold), 32'd0);
    chk("t1_done", 32'(done), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    chk("t1_ready", 32'(rx_ready), 32'd0);

    // 2: four-byte image, one write per lane
    do_reset();
    frm = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
    send_frame();
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_hold", 32'(cpu_hold), 32'd0);
    chk("t2_ready", 32'(rx_ready), 32'd0);
    chk("t2_err", 32'(err), 32'd0);
    drain("t2_drain");

    // 3: five-byte image wraps to word 1 lane 0
    do_reset();
    frm = '{8'hA5, 8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hF1};
    send_frame();
    chk("t3_done", 32'(done), 32'd1);
    drain("t3_drain");

    // 4: bad checksum, then a good frame whose data contains the sync value
    do_reset();
    frm = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'h00};
    send_frame();
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    chk("t4_ready", 32'(rx_ready), 32'd1);
    chk("t4_done", 32'(done), 32'd0);
    drain("t4_drain_bad");
    frm = '{8'hA5, 8'h02, 8'h00, 8'hA5, 8'h10, 8'h4B};
    send_frame();
    chk("t4_err_clr", 32'(err), 32'd0);
    chk("t4_done_good", 32'(done), 32'd1);
    drain("t4_drain_good");

    // 4b: empty image
    do_reset();
    frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame();
    chk("t4b_done", 32'(done), 32'd1);
    chk("t4b_hold", 32'(cpu_hold), 32'd0);

    // 5: oversize length, then a stalled frame
    do_reset();
    frm = '{8'hA5, 8'h01, 8'h20};
    send_frame();
    chk("t5_len_err", 32'(err), 32'd1);
    chk("t5_len_ready", 32'(rx_ready), 32'd1);
    frm = '{8'hA5, 8'h03, 8'h00, 8'h01};
    send_frame();
    chk("t5_err_clr", 32'(err), 32'd0);
    repeat (TO - 2) @(posedge clk);
    #1 chk("t5_err_early", 32'(err), 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("t5_to_err", 32'(err), 32'd1);
    chk("t5_to_hold", 32'(cpu_hold), 32'd1);
    drain("t5_drain");

    // 6: reset mid-DATA
    do_reset();
    frm = '{8'hA5, 8'h04, 8'h00, 8'h11, 8'h22};
    send_frame();
    resetn = 1'b0;
    @(posedge clk);
    #1 chk("t6_ce", 32'(ram_ce), 32'd0);
    chk("t6_wre", 32'(ram_wre), 32'd0);
    chk("t6_ad", 32'(ram_ad), 32'd0);
    chk("t6_din", 32'(ram_din), 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    send_byte(8'h33);
    send_byte(8'h44);
    chk("t6_idle_ready", 32'(rx_ready), 32'd1);
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
